// File: rtl/xl_pkg.sv
// Shared types and constants for the reboot controller.
// State encoding, reboot cause codes and the default software key.
package xl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_DELAY,
        ST_FIRE
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_SW   = 2'd1;
    localparam logic [1:0] CAUSE_WDT  = 2'd2;

    localparam logic [7:0] DEFAULT_KEY = 8'hA5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reboot_wdt.sv
// Watchdog counter: runs while enabled in IDLE, kick or disable clears it.
// Expiry is a single-cycle pulse; a kick on the expiry cycle suppresses it.
module reboot_wdt
    import xl_pkg::*;
#(
    parameter int WDT_CYCLES = 100
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_kick,
    output logic o_expire
);

    localparam int W = $clog2(WDT_CYCLES + 1) + 1;

    logic [W-1:0] r_cnt;
    logic         w_hit;

    assign w_hit    = (r_cnt == W'(WDT_CYCLES - 1));
    assign o_expire = i_run & ~i_kick & w_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_run || i_kick || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/reboot_ctrl.sv
// Reboot arbiter: keyed sw request or watchdog, flash drain, settle delay,
// then a glitch-free registered 'reboot' level held for the ICAP sequence.
module reboot_ctrl
    import xl_pkg::*;
#(
    parameter logic [7:0] KEY          = DEFAULT_KEY,
    parameter int         DELAY_CYCLES = 1000,
    parameter int         HOLD_CYCLES  = 64,
    parameter int         DRAIN_TMO    = 65535,
    parameter int         WDT_CYCLES   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [7:0] req_key,
    output logic       req_ready,
    input  logic       abort,
    input  logic       flash_busy,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       reboot,
    output logic       busy,
    output logic [1:0] cause,
    output logic       key_err,
    output logic       fail
);

    localparam int MAXB = max3(DELAY_CYCLES, HOLD_CYCLES, DRAIN_TMO);
    localparam int CW   = $clog2(MAXB + 1) + 1;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_reboot;
    logic [1:0]    r_cause;
    logic          r_key_err;
    logic          r_fail;
    logic          w_idle;
    logic          w_wdt_exp;

    assign w_idle    = (r_state == ST_IDLE);
    assign req_ready = w_idle;
    assign busy      = ~w_idle;
    assign reboot    = r_reboot;
    assign cause     = r_cause;
    assign key_err   = r_key_err;
    assign fail      = r_fail;

    generate
        if (WDT_CYCLES > 0) begin : g_wdt
            reboot_wdt #(
                .WDT_CYCLES(WDT_CYCLES)
            ) u_wdt (
                .i_clk   (clk),
                .i_rst_n (rst_n),
                .i_run   (wdt_en & w_idle),
                .i_kick  (wdt_kick),
                .o_expire(w_wdt_exp)
            );
        end else begin : g_nowdt
            logic w_unused_wdt;
            assign w_unused_wdt = wdt_en ^ wdt_kick;
            assign w_wdt_exp    = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_reboot  <= 1'b0;
            r_cause   <= CAUSE_NONE;
            r_key_err <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_key_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    // watchdog outranks a same-cycle sw request
                    if (w_wdt_exp) begin
                        r_state <= ST_DRAIN;
                        r_cause <= CAUSE_WDT;
                        r_fail  <= 1'b0;
                    end else if (req_valid) begin
                        if (req_key == KEY) begin
                            r_state <= ST_DRAIN;
                            r_cause <= CAUSE_SW;
                            r_fail  <= 1'b0;
                        end else begin
                            r_key_err <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (!flash_busy ||
                                 r_cnt == CW'(DRAIN_TMO - 1)) begin
                        r_state <= ST_DELAY;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CW'(DELAY_CYCLES - 1)) begin
                        r_state <= ST_FIRE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FIRE: begin
                    if (r_cnt == CW'(HOLD_CYCLES)) begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        r_reboot <= 1'b0;
                        r_fail   <= 1'b1;
                    end else begin
                        r_reboot <= 1'b1;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
